jesd204b_tx_link: RTL

Single-lane JESD204B subclass-1 transmit link layer, the transmit-side counterpart of `jesd204b_rx_con`. It generates the LMFC from SYSREF and runs code-group synchronisation (CGS) and the initial lane alignment sequence (ILAS) against the receiver's SYNC~. It then passes user octets to the transceiver TX user-data and TXCTRL2 (char-is-K) inputs. It emits one 4-octet beat per `i_dclk` cycle; scrambling is not implemented.

---
 rtl/jesd204b_pkg.sv | 19 +
 rtl/jesd204b_lmfc_gen.sv | 48 ++++
 rtl/jesd204b_tx_link.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/jesd204b_pkg.sv
// Shared JESD204B definitions: control characters, link states and ILAS geometry.
// Used by both the TX and RX link layers.
package jesd204b_pkg;

  localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start
  localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end
  localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ config follows
  localparam logic [7:0] K28_5 = 8'hBC;  // /K/ code-group sync

  localparam int ILAS_MF    = 4;
  localparam int CFG_OCTETS = 14;

  typedef enum logic [1:0] {
    CGS  = 2'd0,
    ILAS = 2'd1,
    DATA = 2'd2
  } link_state_t;

endpackage

// File: rtl/jesd204b_lmfc_gen.sv
// LMFC generator: samples SYSREF, detects its rising edge and runs the
// beat-per-multiframe counter that realigns to it.
module jesd204b_lmfc_gen #(
  parameter int BPM   = 8,
  parameter int CNT_W = $clog2(BPM)
) (
  input  logic             i_dclk,
  input  logic             i_rst,
  input  logic             i_sysref,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_boundary,
  output logic             o_last,
  output logic             o_phase_change
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BPM - 1);

  logic             r_sysref;
  logic             r_sysref_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             w_edge;
  logic             w_last;

  assign w_edge = r_sysref & ~r_sysref_prev;
  assign w_last = (r_cnt == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_dclk or posedge i_rst) begin
    if (i_rst) begin
      r_sysref      <= 1'b0;
      r_sysref_prev <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_sysref      <= i_sysref;
      r_sysref_prev <= r_sysref;
      if (w_edge || w_last) r_cnt <= '0;
      else                  r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt          = r_cnt;
  assign o_boundary     = (r_cnt == '0);
  assign o_last         = w_last;
  // An edge landing on the last beat reloads the value the wrap gives anyway.
  assign o_phase_change = w_edge & ~w_last;

endmodule

// File: rtl/jesd204b_tx_link.sv
// Single-lane JESD204B subclass-1 TX link layer: CGS, ILAS and user data,
// four octets per beat, synchronised to the receiver's SYNC~ and to SYSREF.
module jesd204b_tx_link
  import jesd204b_pkg::*;
#(
  parameter int FRAME_SIZE = 1,
  parameter int FMLC_NUM   = 32
) (
  input  logic         i_dclk,
  input  logic         i_rst,
  input  logic         i_sysref,
  input  logic         i_nsync,
  input  logic [111:0] i_cfg,
  input  logic [31:0]  i_data,
  output logic         o_ready,
  output logic [31:0]  o_txdata,
  output logic [3:0]   o_txcharisk,
  output logic [1:0]   o_state,
  output logic         o_lmfc
);

  localparam int OCTETS_MF = FRAME_SIZE * FMLC_NUM;
  localparam int BPM       = OCTETS_MF / 4;
  localparam int CNT_W     = $clog2(BPM);
  localparam int IDX_W     = CNT_W + 2;

  // Returns {is_k, octet} for one lane of an ILAS beat.
  function automatic logic [8:0] ilas_octet(input logic [1:0]       mf,
                                            input logic [CNT_W-1:0] beat,
                                            input logic [1:0]       lane,
                                            input logic [111:0]     cfg);
    logic [IDX_W-1:0] idx;
    logic [6:0]       lsb;
    idx = {beat, lane};
    lsb = 7'(idx - IDX_W'(2)) << 3;
    if (idx == '0)                        return {1'b1, K28_0};
    if (idx == IDX_W'(OCTETS_MF - 1))     return {1'b1, K28_3};
    if (mf == 2'd1 && idx == IDX_W'(1))   return {1'b1, K28_4};
    if (mf == 2'd1 && idx >= IDX_W'(2) && idx < IDX_W'(CFG_OCTETS + 2))
      return {1'b0, cfg[lsb +: 8]};
    return {1'b0, 8'(idx)};
  endfunction

  logic [CNT_W-1:0] w_lmfc_cnt;
  logic             w_lmfc_boundary;
  logic             w_lmfc_last;
  logic             w_phase_change;

  jesd204b_lmfc_gen #(.BPM(BPM), .CNT_W(CNT_W)) u_lmfc (
    .i_dclk        (i_dclk),
    .i_rst         (i_rst),
    .i_sysref      (i_sysref),
    .o_cnt         (w_lmfc_cnt),
    .o_boundary    (w_lmfc_boundary),
    .o_last        (w_lmfc_last),
    .o_phase_change(w_phase_change)
  );

  logic        r_nsync_meta;
  logic        r_nsync_sync;
  logic        r_nsync_prev;
  link_state_t r_state;
  link_state_t w_next_state;
  logic [1:0]  r_ilas_mf;
  logic        w_ilas_done;
  logic [8:0]  w_ilas [4];
  logic [31:0] w_txdata;
  logic [3:0]  w_txcharisk;
  logic [31:0] r_txdata;
  logic [3:0]  r_txcharisk;
  link_state_t r_state_q;
  logic        r_ready;
  logic        r_lmfc;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign w_ilas[g] = ilas_octet(r_ilas_mf, w_lmfc_cnt, 2'(g), i_cfg);
  end

  assign w_ilas_done = (r_ilas_mf == 2'(ILAS_MF - 1)) && w_lmfc_last;

  // NOTE: every combinational output is given a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_txdata     = {4{K28_5}};
    w_txcharisk  = 4'hF;
    unique case (r_state)
      CGS: begin
        if (r_nsync_sync && w_lmfc_last) w_next_state = ILAS;
      end
      ILAS: begin
        if (!r_nsync_sync || w_phase_change) w_next_state = CGS;
        else if (w_ilas_done)                w_next_state = DATA;
        w_txdata    = {w_ilas[3][7:0], w_ilas[2][7:0], w_ilas[1][7:0], w_ilas[0][7:0]};
        w_txcharisk = {w_ilas[3][8], w_ilas[2][8], w_ilas[1][8], w_ilas[0][8]};
      end
      DATA: begin
        // A single-cycle SYNC~ glitch is tolerated once user data is flowing.
        if ((!r_nsync_sync && !r_nsync_prev) || w_phase_change) w_next_state = CGS;
        w_txdata    = i_data;
        w_txcharisk = 4'h0;
      end
      default: w_next_state = CGS;
    endcase
  end

  always_ff @(posedge i_dclk or posedge i_rst) begin
    if (i_rst) begin
      r_nsync_meta <= 1'b0;
      r_nsync_sync <= 1'b0;
      r_nsync_prev <= 1'b0;
      r_state      <= CGS;
      r_ilas_mf    <= '0;
      r_txdata     <= {4{K28_5}};
      r_txcharisk  <= 4'hF;
      r_state_q    <= CGS;
      r_ready      <= 1'b0;
      r_lmfc       <= 1'b0;
    end else begin
      r_nsync_meta <= i_nsync;
      r_nsync_sync <= r_nsync_meta;
      r_nsync_prev <= r_nsync_sync;
      r_state      <= w_next_state;
      if (r_state != ILAS) r_ilas_mf <= '0;
      else if (w_lmfc_last) r_ilas_mf <= r_ilas_mf + 2'd1;
      r_txdata     <= w_txdata;
      r_txcharisk  <= w_txcharisk;
      r_state_q    <= r_state;
      // Ready is high exactly in the cycles whose i_data gets registered.
      r_ready      <= (w_next_state == DATA);
      r_lmfc       <= w_lmfc_boundary;
    end
  end

  assign o_txdata    = r_txdata;
  assign o_txcharisk = r_txcharisk;
  assign o_state     = r_state_q;
  assign o_ready     = r_ready;
  assign o_lmfc      = r_lmfc;

endmodule
